// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU operation codes shared with the ALU control decoder
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Which iterative operation the multi-cycle core is running
  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

endpackage

// File: rtl/seq_muldiv_core.sv
// rtl/seq_muldiv_core.sv - iterative shift-add multiplier / restoring signed divider
module seq_muldiv_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  md_mode_e         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // acc: product (MUL) or partial remainder (DIV, one guard bit)
  // sh : shifted multiplicand (MUL) or dividend/quotient shift register (DIV)
  // opd: multiplier consumed LSB-first (MUL) or divisor magnitude (DIV)
  logic             active;
  md_mode_e         mode_q;
  logic             neg_q;
  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] opd, opd_n;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // One iteration step of whichever operation is in flight
  always_comb begin
    acc_n   = acc;
    sh_n    = sh;
    opd_n   = opd;
    shifted = '0;
    diff    = '0;
    if (mode_q == MD_MUL) begin
      if (opd[0]) acc_n = {1'b0, acc[WIDTH-1:0] + sh};
      sh_n  = sh << 1;
      opd_n = opd >> 1;
    end else begin
      shifted = {acc[WIDTH-1:0], sh[WIDTH-1]};
      diff    = shifted - {1'b0, opd};
      if (!diff[WIDTH]) begin
        acc_n = diff;
        sh_n  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted;
        sh_n  = {sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  // fin/res describe the step being taken this cycle, so the FSM can latch on the last one
  assign fin = active && (count == LAST);
  assign res = (mode_q == MD_MUL) ? acc_n[WIDTH-1:0] : (neg_q ? -sh_n : sh_n);

  // Operand load on go, then one bit per cycle until the last step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      mode_q <= MD_MUL;
      neg_q  <= 1'b0;
      acc    <= '0;
      sh     <= '0;
      opd    <= '0;
      count  <= '0;
    end else if (go) begin
      active <= 1'b1;
      mode_q <= mode;
      count  <= '0;
      acc    <= '0;
      if (mode == MD_MUL) begin
        sh    <= a;
        opd   <= b;
        neg_q <= 1'b0;
      end else begin
        sh    <= a_mag;
        opd   <= b_mag;
        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      end
    end else if (active) begin
      acc   <= acc_n;
      sh    <= sh_n;
      opd   <= opd_n;
      count <= count + 1'b1;
      if (fin) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with start/busy/done handshake
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] single;
  logic             is_mul, is_div, div0, go, core_fin;
  md_mode_e         core_mode;
  logic [WIDTH-1:0] core_res;

  assign is_mul    = (ALU_control == ALU_MUL);
  assign is_div    = (ALU_control == ALU_DIV);
  assign div0      = is_div && (b == '0);
  assign go        = (state == ST_IDLE) && start && (is_mul || (is_div && !div0));
  assign core_mode = is_div ? MD_DIV : MD_MUL;

  // Single-cycle results; DIV only reaches here when dividing by zero
  always_comb begin
    single = '0;
    case (ALU_control)
      ALU_AND: single = a & b;
      ALU_OR:  single = a | b;
      ALU_ADD: single = a + b;
      ALU_SUB: single = a - b;
      ALU_SLT: single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: single = ~(a | b);
      ALU_DIV: single = '1;
      default: single = '0;
    endcase
  end

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .mode  (core_mode),
    .a     (a),
    .b     (b),
    .fin   (core_fin),
    .res   (core_res)
  );

  // Control FSM: accept in IDLE, wait on the core for MUL/DIV, one DONE cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      result      <= '0;
      zero        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= div0;
            if (go) begin
              state <= is_div ? ST_DIV : ST_MUL;
            end else begin
              result <= single;
              zero   <= (single == '0);
              done   <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_fin) begin
            result <= core_res;
            zero   <= (core_res == '0);
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   code = 4'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         zero, busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ALU_control (code),
    .a           (a),
    .b           (b),
    .result      (result),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [63:0] sx, sy, q;
    logic [63:0] p;
    sx = 64'($signed(x));
    sy = 64'($signed(y));
    case (c)
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_SLT: return (sx < sy) ? 32'd1 : 32'd0;
      ALU_NOR: return ~(x | y);
      ALU_MUL: begin
        p = {32'b0, x} * {32'b0, y};
        return p[31:0];
      end
      ALU_DIV: begin
        if (y == 0) return 32'hFFFFFFFF;
        q = sx / sy;
        return q[31:0];
      end
      default: return '0;
    endcase
  endfunction

  // Reference model: accepted op -> expected value and number of edges until done
  bit           m_busy = 0, m_done = 0, m_dbz = 0;
  int           m_left = 0;
  logic [W-1:0] m_result = '0, m_pend = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_dbz <= 0; m_left <= 0; m_result <= '0;
    end else if (!m_busy) begin
      m_done <= 0;
      if (start) begin
        m_busy <= 1;
        m_dbz  <= (code == ALU_DIV) && (b == 0);
        if (code == ALU_MUL || (code == ALU_DIV && b != 0)) begin
          m_left <= W;
          m_pend <= ref_result(code, a, b);
        end else begin
          m_done   <= 1;
          m_result <= ref_result(code, a, b);
        end
      end
    end else if (m_done) begin
      m_done <= 0;
      m_busy <= 0;
    end else begin
      if (m_left == 1) begin
        m_done   <= 1;
        m_result <= m_pend;
      end
      m_left <= m_left - 1;
    end
  end

  // Every-cycle comparison of the DUT outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("dbz", 32'(div_by_zero), 32'(m_dbz));
      check("result", result, m_result);
      check("zero", 32'(zero), 32'(m_result == 0));
    end
  end

  task automatic run_op(input string name, input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_res, input int exp_lat, input bit exp_dbz);
    int lat;
    @(negedge clk);
    start = 1; code = c; a = x; b = y;
    @(negedge clk);
    start = 0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, result, exp_res);
    check({name, "_zero"}, 32'(zero), 32'(exp_res == 0));
    check({name, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  logic [3:0] ops [8] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL, ALU_DIV};

  initial begin
    int lat, ndone;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1;
    check("rst_result", result, 32'h0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1;

    run_op("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1, 0);
    check("add_busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("add_busy_after", 32'(busy), 32'd0);
    run_op("sub", ALU_SUB, 32'd3, 32'd3, 32'd0, 1, 0);
    run_op("slt", ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0);
    run_op("nor", ALU_NOR, 32'd0, 32'd0, 32'hFFFFFFFF, 1, 0);
    run_op("mul", ALU_MUL, 32'd7, 32'd6, 32'd42, 33, 0);
    run_op("mul_wrap", ALU_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33, 0);
    run_op("div_neg", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
    run_op("div_zero", ALU_DIV, 32'd100, 32'd0, 32'hFFFFFFFF, 1, 1);
    run_op("div_min", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0);
    run_op("and_clr_dbz", ALU_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 1, 0);

    // start while busy is ignored
    @(negedge clk);
    start = 1; code = ALU_MUL; a = 9; b = 9;
    @(negedge clk);
    start = 0;
    lat = 0; ndone = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 4) begin start = 1; code = ALU_ADD; a = 1; b = 1; end
      if (i == 5) start = 0;
      if (done) begin
        ndone++;
        if (lat == 0) lat = i;
        check("ign_res", result, 32'd81);
      end
      @(negedge clk);
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_lat", 32'(lat), 32'd33);

    // reset mid-iteration aborts with no done
    start = 1; code = ALU_MUL; a = 3; b = 5;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_ndone", 32'(ndone), 32'd0);
    run_op("add_after_rst", ALU_ADD, 32'd1, 32'd1, 32'd2, 1, 0);

    // randomized traffic, occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom % 500) != 0;
      start = ($urandom % 3) == 0;
      code  = (($urandom % 4) == 0) ? 4'($urandom) : ops[$urandom % 8];
      a     = rnd_val();
      b     = rnd_val();
    end
    @(negedge clk);
    rst_n = 1; start = 0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
